// File: rtl/game_flow_ctrl_if.sv
// Key/event inputs and status outputs between the game logic and game_flow_ctrl.
// The controller takes the slave side; the surrounding game (or a bench) takes master.
interface game_flow_ctrl_if;
  logic       startKey;
  logic       startOfFrame;
  logic       playerHit;
  logic       aliensCleared;
  logic       aliensLanded;
  logic       startPulse;
  logic       playing;
  logic       gameOver;
  logic       win;
  logic [2:0] lives;
  logic [1:0] stateOut;

  modport master (
    output startKey, startOfFrame, playerHit, aliensCleared, aliensLanded,
    input  startPulse, playing, gameOver, win, lives, stateOut
  );

  modport slave (
    input  startKey, startOfFrame, playerHit, aliensCleared, aliensLanded,
    output startPulse, playing, gameOver, win, lives, stateOut
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game sequencer: debounced start, one-cycle start pulse, lives, end-of-game hold.
// Define AUTO_RESTART_EN to make OVER restart a game automatically (or on a press).
module game_flow_ctrl #(
  parameter int LIVES_INIT      = 3,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int OVER_FRAMES     = 120
) (
  input  logic             clk,
  input  logic             rst_n,
  game_flow_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam logic [3:0] DEB_MAX    = 4'(DEBOUNCE_FRAMES);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
  localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);

  logic [1:0] state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic       win_q, win_d;
  logic [3:0] deb_q, deb_d;
  logic       rel_q, rel_d;
  logic [7:0] frame_q, frame_d;
  logic       start_pulse_q, playing_q, game_over_q;
  logic       press;

  assign press = (deb_q == DEB_MAX) && rel_q;

  // A press always consumes the key: it must be released before it can count again.
  always_comb begin
    deb_d = deb_q;
    rel_d = rel_q;
`ifndef AUTO_RESTART_EN
    if (state_q == S_OVER) begin
      deb_d = 4'd0;
      rel_d = 1'b0;
    end else
`endif
    if (press) begin
      deb_d = 4'd0;
      rel_d = 1'b0;
    end else if (bus.startOfFrame) begin
      if (!bus.startKey) begin
        deb_d = 4'd0;
        rel_d = 1'b1;
      end else if (rel_q && (deb_q != DEB_MAX)) begin
        deb_d = deb_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    win_d   = win_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (press) state_d = S_ARM;
      end
      S_ARM: begin
        state_d = S_PLAY;
        lives_d = LIVES_LOAD;
        win_d   = 1'b0;
      end
      S_PLAY: begin
        if (bus.aliensLanded) begin
          lives_d = 3'd0;
          win_d   = 1'b0;
          state_d = S_OVER;
          frame_d = 8'd0;
        end else if (bus.aliensCleared) begin
          win_d   = 1'b1;
          state_d = S_OVER;
          frame_d = 8'd0;
        end else if (bus.playerHit) begin
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
          end else begin
            lives_d = 3'd0;
            win_d   = 1'b0;
            state_d = S_OVER;
            frame_d = 8'd0;
          end
        end
      end
      default: begin
        if (bus.startOfFrame) begin
          if (frame_q == OVER_LAST) begin
`ifdef AUTO_RESTART_EN
            state_d = S_ARM;
`else
            state_d = S_IDLE;
`endif
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end
`ifdef AUTO_RESTART_EN
        if (press) state_d = S_ARM;
`endif
      end
    endcase
  end

  // Status flags decode the next state so they line up with state_q without input paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      lives_q       <= 3'd0;
      win_q         <= 1'b0;
      deb_q         <= 4'd0;
      rel_q         <= 1'b0;
      frame_q       <= 8'd0;
      start_pulse_q <= 1'b0;
      playing_q     <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      win_q         <= win_d;
      deb_q         <= deb_d;
      rel_q         <= rel_d;
      frame_q       <= frame_d;
      start_pulse_q <= (state_d == S_ARM);
      playing_q     <= (state_d == S_PLAY);
      game_over_q   <= (state_d == S_OVER);
    end
  end

  assign bus.startPulse = start_pulse_q;
  assign bus.playing    = playing_q;
  assign bus.gameOver   = game_over_q;
  assign bus.win        = win_q;
  assign bus.lives      = lives_q;
  assign bus.stateOut   = state_q;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Game-level sequencer that produces the start request consumed by the game reset generator.
- Debounces the start key, issues a one-cycle start pulse, tracks lives, and collects end-of-game events from the player, alien and collision blocks.
- Holds the game-over/win screen for a fixed number of frames, then returns to the attract (idle) screen.
- Sits between the key interface and the reset generator; its status outputs drive the screen/text mux.

Parameters:
- LIVES_INIT, 3, lives loaded at each game start (1..7).
- DEBOUNCE_FRAMES, 4, consecutive frames the start key must be high to count as a press (1..15).
- OVER_FRAMES, 120, frames the game-over/win screen is held (1..255).

Ports:
- clk  in  1  system clock.
- resetN  in  1  async active-low reset.
- startKey  in  1  raw start key level, already synchronised to clk.
- startOfFrame  in  1  one-cycle pulse per video frame.
- playerHit  in  1  one-cycle pulse: player destroyed.
- aliensCleared  in  1  one-cycle pulse: last alien destroyed.
- aliensLanded  in  1  one-cycle pulse: alien reached player row.
- startPulse  out  1  one-cycle pulse to the reset generator's start input.
- playing  out  1  high in PLAY.
- gameOver  out  1  high in OVER.
- win  out  1  in OVER: 1 = cleared, 0 = lost; held until next start.
- lives  out  3  remaining lives.
- stateOut  out  2  IDLE=0, ARM=1, PLAY=2, OVER=3.

Behaviour:
- Reset (resetN low, asynchronous) gives state IDLE, startPulse=0, playing=0, gameOver=0, win=0, lives=0, all counters 0, keyReleased=0.
- Debounce logic updates only on startOfFrame:
  - startKey low: debounce counter clears and keyReleased is set.
  - startKey high and keyReleased=1: counter increments, saturating at DEBOUNCE_FRAMES.
  - press = counter==DEBOUNCE_FRAMES && keyReleased. On press, keyReleased clears and the counter clears.
- A key held through reset or OVER does not start a game; it must be released first.
- IDLE: on press, go to ARM. Play events are ignored.
- ARM: lasts exactly 1 cycle.
  - startPulse=1, lives<=LIVES_INIT, win<=0.
  - Next state is PLAY.
- PLAY: events are sampled every cycle, not frame-gated. When events coincide, priority is aliensLanded > aliensCleared > playerHit.
  - aliensLanded: lives<=0, win<=0, go to OVER.
  - aliensCleared: win<=1, go to OVER. Lives are unchanged.
  - playerHit with lives>1: lives<=lives-1, stay in PLAY.
  - playerHit with lives==1: lives<=0, win<=0, go to OVER.
- OVER:
  - The frame counter clears on entry and increments on each startOfFrame.
  - When the counter reaches OVER_FRAMES-1 and startOfFrame is high, go to IDLE.
  - Play events and start presses are ignored; the debounce counter stays cleared.
- startOfFrame coinciding with state entry is counted by the new state.
- lives never wraps below 0.
- stateOut, playing and gameOver are registered decodes of the state, with no combinational path from the inputs.
- Reset mid-game behaves as power-up: the game returns to IDLE, and a new press requires key release first.

Optional Feature:
- Macro: AUTO_RESTART_EN.
- Defined: when the OVER timeout expires, go directly to ARM, giving an automatic new game with a startPulse. A debounced press during OVER also cuts the screen short and goes to ARM.
- Undefined: the OVER timeout goes to IDLE and presses in OVER are ignored, as described in Behaviour.

Test Plan:
- Reset, then hold startKey high for 4 frames → no startPulse, because no release was seen.
- Release startKey, then hold it 4 frames → startPulse high for exactly 1 cycle, then stateOut=2 and lives=3.
- In PLAY, send 3 playerHit pulses → lives 3→2→1→0. On the third, gameOver=1 and win=0. After 120 startOfFrame pulses, stateOut=0.
- In PLAY, assert aliensCleared and playerHit in the same cycle → OVER with win=1 and lives=3.
- Assert aliensLanded with lives=3 → lives=0, win=0, OVER. Pulse startKey during OVER → ignored without AUTO_RESTART_EN; with the macro, go to ARM.
- Deassert resetN mid-PLAY for 1 cycle (async, between clock edges) → outputs go to their reset values immediately and state is IDLE.
